// File: rtl/otter_exec_unit.sv
// Registered execute stage for the OTTER RV32I pipeline: ALU, branch targets and branch compares.
// Optional macro EXU_ZERO_FLAG_EN adds a registered ZERO flag that tracks RESULT == 0.
module otter_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN,
   input  logic [3:0]      ALU_FUN,
   input  logic [XLEN-1:0] SRC_A,
   input  logic [XLEN-1:0] SRC_B,
   input  logic [XLEN-1:0] RS1,
   input  logic [XLEN-1:0] RS2,
   input  logic [XLEN-1:0] PC,
   input  logic [XLEN-1:0] I_TYPE,
   input  logic [XLEN-1:0] J_TYPE,
   input  logic [XLEN-1:0] B_TYPE,
   output logic [XLEN-1:0] RESULT,
   output logic [XLEN-1:0] JAL,
   output logic [XLEN-1:0] JALR,
   output logic [XLEN-1:0] BRANCH,
   output logic            BR_EQ,
   output logic            BR_LT,
   output logic            BR_LTU,
`ifdef EXU_ZERO_FLAG_EN
   output logic            ZERO,
`endif
   output logic            VALID
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] FUN_ADD  = 4'b0000;
   localparam logic [3:0] FUN_SUB  = 4'b1000;
   localparam logic [3:0] FUN_OR   = 4'b0110;
   localparam logic [3:0] FUN_AND  = 4'b0111;
   localparam logic [3:0] FUN_XOR  = 4'b0100;
   localparam logic [3:0] FUN_SLL  = 4'b0001;
   localparam logic [3:0] FUN_SRL  = 4'b0101;
   localparam logic [3:0] FUN_SRA  = 4'b1101;
   localparam logic [3:0] FUN_SLT  = 4'b0010;
   localparam logic [3:0] FUN_SLTU = 4'b0011;
   localparam logic [3:0] FUN_LUI  = 4'b1001;

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_next;
   logic [XLEN-1:0] jal_next;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_next;
   logic [XLEN-1:0] branch_next;
   logic            eq_next;
   logic            lt_next;
   logic            ltu_next;

   assign shamt = SRC_B[SHW-1:0];

   always_comb begin
      alu_next = '0;
      case (ALU_FUN)
         FUN_ADD:  alu_next = SRC_A + SRC_B;
         FUN_SUB:  alu_next = SRC_A - SRC_B;
         FUN_OR:   alu_next = SRC_A | SRC_B;
         FUN_AND:  alu_next = SRC_A & SRC_B;
         FUN_XOR:  alu_next = SRC_A ^ SRC_B;
         FUN_SLL:  alu_next = SRC_A << shamt;
         FUN_SRL:  alu_next = SRC_A >> shamt;
         FUN_SRA:  alu_next = $unsigned($signed(SRC_A) >>> shamt);
         FUN_SLT:  alu_next = {{(XLEN-1){1'b0}}, $signed(SRC_A) < $signed(SRC_B)};
         FUN_SLTU: alu_next = {{(XLEN-1){1'b0}}, SRC_A < SRC_B};
         FUN_LUI:  alu_next = SRC_A;
         default:  alu_next = '0;
      endcase
   end

   // Target adders wrap; JALR drops bit 0 with no further alignment check.
   assign jal_next    = PC + J_TYPE;
   assign branch_next = PC + B_TYPE;
   assign jalr_sum    = RS1 + I_TYPE;
   assign jalr_next   = {jalr_sum[XLEN-1:1], 1'b0};

   assign eq_next  = (RS1 == RS2);
   assign lt_next  = ($signed(RS1) < $signed(RS2));
   assign ltu_next = (RS1 < RS2);

   // Reset beats enable; with EN low the data registers hold and VALID drops.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RESULT <= '0;
         JAL    <= '0;
         JALR   <= '0;
         BRANCH <= '0;
         BR_EQ  <= 1'b0;
         BR_LT  <= 1'b0;
         BR_LTU <= 1'b0;
         VALID  <= 1'b0;
      end else begin
         VALID <= EN;
         if (EN) begin
            RESULT <= alu_next;
            JAL    <= jal_next;
            JALR   <= jalr_next;
            BRANCH <= branch_next;
            BR_EQ  <= eq_next;
            BR_LT  <= lt_next;
            BR_LTU <= ltu_next;
         end
      end
   end

`ifdef EXU_ZERO_FLAG_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         ZERO <= 1'b0;
      end else if (EN) begin
         ZERO <= (alu_next == '0);
      end
   end
`endif

endmodule

// File: tb/tb_otter_exec_unit.sv
// Self-checking bench for otter_exec_unit: arithmetic reference model plus literal spot checks.
// Honours EXU_ZERO_FLAG_EN to connect and check the optional ZERO output.
module tb_otter_exec_unit;

   logic        CLK = 1'b0;
   logic        RST, EN;
   logic [3:0]  ALU_FUN;
   logic [31:0] SRC_A, SRC_B, RS1, RS2, PC, I_TYPE, J_TYPE, B_TYPE;
   logic [31:0] RESULT, JAL, JALR, BRANCH;
   logic        BR_EQ, BR_LT, BR_LTU, VALID;
`ifdef EXU_ZERO_FLAG_EN
   logic        ZERO;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   otter_exec_unit #(.XLEN(32)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .ALU_FUN(ALU_FUN),
      .SRC_A(SRC_A), .SRC_B(SRC_B), .RS1(RS1), .RS2(RS2), .PC(PC),
      .I_TYPE(I_TYPE), .J_TYPE(J_TYPE), .B_TYPE(B_TYPE),
      .RESULT(RESULT), .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH),
      .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
`ifdef EXU_ZERO_FLAG_EN
      .ZERO(ZERO),
`endif
      .VALID(VALID)
   );

   // Reference ALU expressed as plain integer arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua, ub, p;
      int sh;
      ua = a; ub = b;
      sh = b % 32;
      p  = 64'd1 << sh;
      case (f)
         4'b0000: return 32'((ua + ub) % 64'h1_0000_0000);
         4'b1000: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b0100: return a ^ b;
         4'b0001: return 32'((ua * p) % 64'h1_0000_0000);
         4'b0101: return 32'(ua / p);
         4'b1101: return a[31] ? ~32'((~ua & 64'hFFFF_FFFF) / p) : 32'(ua / p);
         4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'b0011: return (ua < ub) ? 32'd1 : 32'd0;
         4'b1001: return a;
         default: return 32'd0;
      endcase
   endfunction

   logic [31:0] m_result, m_jal, m_jalr, m_branch;
   logic        m_eq, m_lt, m_ltu, m_valid, m_zero;
   bit          m_live = 0;

   always @(posedge CLK) begin
      m_live <= 1'b1;
      if (RST) begin
         m_result <= 0; m_jal <= 0; m_jalr <= 0; m_branch <= 0;
         m_eq <= 0; m_lt <= 0; m_ltu <= 0; m_valid <= 0; m_zero <= 0;
      end else begin
         m_valid <= EN;
         if (EN) begin
            m_result <= ref_alu(ALU_FUN, SRC_A, SRC_B);
            m_zero   <= (ref_alu(ALU_FUN, SRC_A, SRC_B) == 0);
            m_jal    <= 32'((longint'(PC) + longint'(J_TYPE)) % 64'h1_0000_0000);
            m_branch <= 32'((longint'(PC) + longint'(B_TYPE)) % 64'h1_0000_0000);
            m_jalr   <= 32'(((longint'(RS1) + longint'(I_TYPE)) % 64'h1_0000_0000) / 2 * 2);
            m_eq     <= (RS1 == RS2);
            m_lt     <= (int'(RS1) < int'(RS2));
            m_ltu    <= (longint'(RS1) < longint'(RS2));
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (m_live) begin
         cmp("m_result", RESULT, m_result);
         cmp("m_jal",    JAL,    m_jal);
         cmp("m_jalr",   JALR,   m_jalr);
         cmp("m_branch", BRANCH, m_branch);
         cmp("m_eq",     32'(BR_EQ),  32'(m_eq));
         cmp("m_lt",     32'(BR_LT),  32'(m_lt));
         cmp("m_ltu",    32'(BR_LTU), 32'(m_ltu));
         cmp("m_valid",  32'(VALID),  32'(m_valid));
`ifdef EXU_ZERO_FLAG_EN
         cmp("m_zero",   32'(ZERO),   32'(m_zero));
`endif
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_inputs();
      ALU_FUN = 4'($urandom); SRC_A = $urandom; SRC_B = $urandom;
      RS1 = $urandom; RS2 = $urandom; PC = $urandom;
      I_TYPE = $urandom; J_TYPE = $urandom; B_TYPE = $urandom;
   endtask

   task automatic chk_all_zero(input string tag);
      cmp({tag, "_result"}, RESULT, 0);
      cmp({tag, "_jal"},    JAL,    0);
      cmp({tag, "_jalr"},   JALR,   0);
      cmp({tag, "_branch"}, BRANCH, 0);
      cmp({tag, "_flags"},  {29'd0, BR_EQ, BR_LT, BR_LTU}, 0);
      cmp({tag, "_valid"},  32'(VALID), 0);
`ifdef EXU_ZERO_FLAG_EN
      cmp({tag, "_zero"},   32'(ZERO), 0);
`endif
   endtask

   typedef struct { logic [3:0] f; logic [31:0] exp; string name; } alu_vec_t;
   alu_vec_t sweep[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1; EN = 1;
      rand_inputs();
      cyc();
      rand_inputs();
      cyc();
      chk_all_zero("reset");

      // Release reset with EN=1: VALID rises one cycle later.
      RST = 0; EN = 1;
      ALU_FUN = 4'b0000; SRC_A = 32'd1; SRC_B = 32'd2;
      cyc();
      cmp("valid_after_release", 32'(VALID), 1);
      cmp("add_1_2", RESULT, 32'd3);

      sweep = '{
         '{4'b0000, 32'hFFFFFFF4, "add"},  '{4'b1000, 32'hFFFFFFEC, "sub"},
         '{4'b0101, 32'h0FFFFFFF, "srl"},  '{4'b1101, 32'hFFFFFFFF, "sra"},
         '{4'b0001, 32'hFFFFFF00, "sll"},  '{4'b0010, 32'h00000001, "slt"},
         '{4'b0011, 32'h00000000, "sltu"}, '{4'b1111, 32'h00000000, "code1111"},
         '{4'b0110, 32'hFFFFFFF4, "or"},   '{4'b0111, 32'h00000000, "and"},
         '{4'b0100, 32'hFFFFFFF4, "xor"},  '{4'b1001, 32'hFFFFFFF0, "lui"}
      };
      SRC_A = 32'hFFFFFFF0; SRC_B = 32'h00000004;
      foreach (sweep[i]) begin
         ALU_FUN = sweep[i].f;
         cyc();
         cmp({"sweep_", sweep[i].name}, RESULT, sweep[i].exp);
      end

      // Shift amount uses only the low 5 bits of B; zero shift is identity.
      SRC_A = 32'h80000001; SRC_B = 32'h00000020; ALU_FUN = 4'b0001;
      cyc();
      cmp("sll_by_32_is_0", RESULT, 32'h80000001);
      SRC_B = 32'h00000024; ALU_FUN = 4'b1101;
      cyc();
      cmp("sra_low_bits", RESULT, 32'hF8000000);

      PC = 32'h100; J_TYPE = 32'hFFFFFFFC; B_TYPE = 32'h10; RS1 = 32'h203; I_TYPE = 32'h4;
      cyc();
      cmp("jal",    JAL,    32'hFC);
      cmp("branch", BRANCH, 32'h110);
      cmp("jalr",   JALR,   32'h206);

      RS1 = 32'h80000000; RS2 = 32'h1;
      cyc();
      cmp("cmp_min_vs_1", {29'd0, BR_EQ, BR_LT, BR_LTU}, 32'b010);
      RS1 = 32'h5; RS2 = 32'h5;
      cyc();
      cmp("cmp_equal", {29'd0, BR_EQ, BR_LT, BR_LTU}, 32'b100);

      ALU_FUN = 4'b0000; SRC_A = 32'h11; SRC_B = 32'h22;
      cyc();
      cmp("pre_hold", RESULT, 32'h33);
      EN = 0;
      for (int k = 0; k < 3; k++) begin
         rand_inputs();
         cyc();
         cmp("hold_result", RESULT, 32'h33);
         cmp("hold_valid",  32'(VALID), 0);
         cmp("hold_eq",     32'(BR_EQ), 1);
      end

      EN = 1; ALU_FUN = 4'b0000; SRC_A = 32'hFFFFFFFF; SRC_B = 32'h1;
      cyc();
      cmp("wrap_add", RESULT, 0);
      cmp("wrap_valid", 32'(VALID), 1);
`ifdef EXU_ZERO_FLAG_EN
      cmp("wrap_zero", 32'(ZERO), 1);
`endif

      for (int k = 0; k < 20; k++) begin
         rand_inputs();
         EN = ($urandom_range(0, 3) != 0);
         cyc();
      end

      EN = 1; RST = 1;
      ALU_FUN = 4'b1001; SRC_A = 32'hDEADBEEF; RS1 = 32'h7; RS2 = 32'h7; PC = 32'h40;
      cyc();
      chk_all_zero("mid_reset");
      RST = 0;
      cyc();
      cmp("post_reset_lui", RESULT, 32'hDEADBEEF);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
